// File: rtl/load_store_unit_pkg.sv
// Shared types and lane helpers for the load/store unit: size codes, FSM states,
// and the byte-lane position of a sub-word access inside a 32-bit memory word.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } state_e;

    localparam int WORD_W = 32;

    // Bit position of the low end of the addressed lane, counted from bit 0.
    function automatic logic [4:0] lane_shift(input logic [1:0] size,
                                              input logic [1:0] offset,
                                              input logic       big_endian);
        logic [1:0] lane;
        if (size == SZ_HALF) begin
            lane = big_endian ? (2'd2 - {offset[1], 1'b0}) : {offset[1], 1'b0};
        end else begin
            lane = big_endian ? (2'd3 - offset) : offset;
        end
        return {lane, 3'b000};
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        return (size == SZ_ILLEGAL) ||
               (size == SZ_HALF && offset[0]) ||
               (size == SZ_WORD && offset != 2'b00);
    endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane logic: extracts and extends load data from a memory word,
// and merges right-justified store data into the addressed lanes of a word.
module lsu_lane_align
    import load_store_unit_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [1:0]  offset,
    input  logic [31:0] mem_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [4:0]  shift;
    logic [31:0] shifted;
    logic [31:0] lane_mask;

    always_comb begin
        shift     = lane_shift(size, offset, BIG_ENDIAN);
        shifted   = mem_word >> shift;
        load_data = mem_word;
        lane_mask = 32'h0000_FFFF << shift;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{is_signed & shifted[7]}}, shifted[7:0]};
                lane_mask = 32'h0000_00FF << shift;
            end
            SZ_HALF: begin
                load_data = {{16{is_signed & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                load_data = mem_word;
            end
        endcase
        // Word stores never come through here for merging, but keep the result sane.
        if (size == SZ_WORD) begin
            merged_word = wdata;
        end else begin
            merged_word = (mem_word & ~lane_mask) | ((wdata << shift) & lane_mask);
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one byte/half/word request at a time and turns it into
// word-wide datamemory accesses, using read-modify-write for sub-word stores.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error,
    output logic [31:0]           mem_address,
    output logic                  mem_read_en,
    output logic                  mem_write_en,
    output logic [31:0]           mem_data_in,
    input  logic [31:0]           mem_data_out
);

    state_e      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [1:0]  offset_q, offset_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic        mem_read_en_q, mem_read_en_d;
    logic        mem_write_en_q, mem_write_en_d;
    logic [31:0] mem_data_in_q, mem_data_in_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_error_q, resp_error_d;

    logic [ADDR_WIDTH-1:0] word_index;
    logic [31:0]           load_data;
    logic [31:0]           merged_word;

    assign word_index = req_addr >> 2;

    lsu_lane_align #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_lane_align (
        .size        (size_q),
        .is_signed   (signed_q),
        .offset      (offset_q),
        .mem_word    (mem_data_out),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_comb begin
        state_d        = state_q;
        write_d        = write_q;
        size_d         = size_q;
        signed_d       = signed_q;
        offset_d       = offset_q;
        wdata_d        = wdata_q;
        mem_address_d  = mem_address_q;
        mem_read_en_d  = 1'b0;
        mem_write_en_d = 1'b0;
        mem_data_in_d  = '0;
        resp_valid_d   = 1'b0;
        resp_rdata_d   = '0;
        resp_error_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d       = req_write;
                    size_d        = req_size;
                    signed_d      = req_signed;
                    offset_d      = req_addr[1:0];
                    wdata_d       = req_wdata;
                    mem_address_d = 32'(word_index);
                    if (is_misaligned(req_size, req_addr[1:0])) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                    end else if (req_write && req_size == SZ_WORD) begin
                        state_d        = ST_WRITE;
                        mem_write_en_d = 1'b1;
                        mem_data_in_d  = req_wdata;
                    end else begin
                        state_d       = ST_READ;
                        mem_read_en_d = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (write_q) begin
                    state_d        = ST_WRITE;
                    mem_write_en_d = 1'b1;
                    mem_data_in_d  = merged_word;
                end else begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_data;
                end
            end
            ST_WRITE: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            write_q        <= 1'b0;
            size_q         <= '0;
            signed_q       <= 1'b0;
            offset_q       <= '0;
            wdata_q        <= '0;
            mem_address_q  <= '0;
            mem_read_en_q  <= 1'b0;
            mem_write_en_q <= 1'b0;
            mem_data_in_q  <= '0;
            resp_valid_q   <= 1'b0;
            resp_rdata_q   <= '0;
            resp_error_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            write_q        <= write_d;
            size_q         <= size_d;
            signed_q       <= signed_d;
            offset_q       <= offset_d;
            wdata_q        <= wdata_d;
            mem_address_q  <= mem_address_d;
            mem_read_en_q  <= mem_read_en_d;
            mem_write_en_q <= mem_write_en_d;
            mem_data_in_q  <= mem_data_in_d;
            resp_valid_q   <= resp_valid_d;
            resp_rdata_q   <= resp_rdata_d;
            resp_error_q   <= resp_error_d;
        end
    end

    // The write strobe is masked by reset so a reset landing in WRITE never commits to memory.
    assign mem_write_en = mem_write_en_q & reset_n;
    assign mem_data_in  = mem_data_in_q & {32{reset_n}};
    assign mem_read_en  = mem_read_en_q;
    assign mem_address  = mem_address_q;
    assign req_ready    = (state_q == ST_IDLE);
    assign resp_valid   = resp_valid_q;
    assign resp_rdata   = resp_rdata_q;
    assign resp_error   = resp_error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small behavioural datamemory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;

    logic [31:0] tb_mem [0:63];

    int checks = 0;
    int errors = 0;

    int          r_lat;
    int          r_rd;
    int          r_wr;
    logic        r_acc;
    logic [31:0] r_rdata;
    logic        r_err;

    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write_en) tb_mem[mem_address[5:0]] <= mem_data_in;
    end
    assign mem_data_out = mem_read_en ? tb_mem[mem_address[5:0]] : 32'hzzzz_zzzz;

    load_store_unit #(
        .ADDR_WIDTH (32),
        .BIG_ENDIAN (1'b1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_signed   (req_signed),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_error   (resp_error),
        .mem_address  (mem_address),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    // Issues one request and records latency, response and memory-enable activity.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        r_acc      = req_ready;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        r_lat   = -1;
        r_rd    = 0;
        r_wr    = 0;
        r_rdata = '0;
        r_err   = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (mem_read_en) r_rd++;
            if (mem_write_en) r_wr++;
            if (resp_valid) begin
                r_lat   = i;
                r_rdata = resp_rdata;
                r_err   = resp_error;
                break;
            end
            @(negedge clk);
        end
        $display("txn wr=%0b size=%0d signed=%0b addr=0x%08h wdata=0x%08h -> lat=%0d rdata=0x%08h err=%0b rd=%0d wr=%0d",
                 wr, sz, sg, addr, wd, r_lat, r_rdata, r_err, r_rd, r_wr);
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size  = 2'b00;
        req_signed = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < 64; i++) tb_mem[i] = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        checks++;
        if ({resp_valid, resp_error, mem_read_en, mem_write_en} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got=%b exp=0000", {resp_valid, resp_error, mem_read_en, mem_write_en});
        end
        checks++;
        if ({resp_rdata, mem_data_in, mem_address} !== 96'h0) begin
            errors++; $display("FAIL reset_data got=%h exp=0", {resp_rdata, mem_data_in, mem_address});
        end
        reset_n = 1'b1;
    endtask

    task automatic test_word_store_load();
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        checks++;
        if (r_acc !== 1'b1) begin errors++; $display("FAIL sw_accept got=%b exp=1", r_acc); end
        checks++;
        if (r_lat != 2) begin errors++; $display("FAIL sw_latency got=%0d exp=2", r_lat); end
        checks++;
        if (tb_mem[4] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_mem got=%h exp=deadbeef", tb_mem[4]); end
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        checks++;
        if (r_lat != 2) begin errors++; $display("FAIL lw_latency got=%0d exp=2", r_lat); end
        checks++;
        if (r_rdata !== 32'hDEAD_BEEF || r_err !== 1'b0) begin
            errors++; $display("FAIL lw_data got=%h err=%b exp=deadbeef err=0", r_rdata, r_err);
        end
    endtask

    task automatic test_subword_store();
        tb_mem[4] = 32'h1122_3344;
        do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AA);
        checks++;
        if (r_lat != 3) begin errors++; $display("FAIL sb_latency got=%0d exp=3", r_lat); end
        checks++;
        if (r_wr != 1 || r_rd != 1) begin errors++; $display("FAIL sb_enables got rd=%0d wr=%0d exp rd=1 wr=1", r_rd, r_wr); end
        checks++;
        if (tb_mem[4] !== 32'h11AA_3344) begin errors++; $display("FAIL sb_mem got=%h exp=11aa3344", tb_mem[4]); end
        tb_mem[5] = 32'hA1B2_C3D4;
        do_req(1'b1, 2'b01, 1'b0, 32'h16, 32'h0000_5566);
        checks++;
        if (tb_mem[5] !== 32'hA1B2_5566) begin errors++; $display("FAIL sh_mem got=%h exp=a1b25566", tb_mem[5]); end
    endtask

    task automatic test_subword_load();
        tb_mem[4] = 32'h11AA_3344;
        do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
        checks++;
        if (r_rdata !== 32'hFFFF_FFAA) begin errors++; $display("FAIL lb_signed got=%h exp=ffffffaa", r_rdata); end
        do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
        checks++;
        if (r_rdata !== 32'h0000_00AA) begin errors++; $display("FAIL lbu got=%h exp=000000aa", r_rdata); end
        do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        checks++;
        if (r_rdata !== 32'h0000_3344) begin errors++; $display("FAIL lhu got=%h exp=00003344", r_rdata); end
        do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        checks++;
        if (r_rdata !== 32'h0000_0044) begin errors++; $display("FAIL lb_off3 got=%h exp=00000044", r_rdata); end
        tb_mem[6] = 32'h8001_7FFF;
        do_req(1'b0, 2'b01, 1'b1, 32'h18, 32'h0);
        checks++;
        if (r_rdata !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_signed got=%h exp=ffff8001", r_rdata); end
        do_req(1'b0, 2'b10, 1'b1, 32'h18, 32'h0);
        checks++;
        if (r_rdata !== 32'h8001_7FFF) begin errors++; $display("FAIL lw_signed got=%h exp=80017fff", r_rdata); end
    endtask

    task automatic test_errors();
        logic [1:0]  sizes [3];
        logic [31:0] addrs [3];
        sizes = '{2'b01, 2'b10, 2'b11};
        addrs = '{32'h13, 32'h12, 32'h10};
        tb_mem[4] = 32'h11AA_3344;
        for (int t = 0; t < 3; t++) begin
            do_req(1'b1, sizes[t], 1'b0, addrs[t], 32'hFFFF_FFFF);
            checks++;
            if (r_lat != 1 || r_err !== 1'b1 || r_rdata !== 32'h0) begin
                errors++; $display("FAIL err_resp_%0d got lat=%0d err=%b rdata=%h exp lat=1 err=1 rdata=0", t, r_lat, r_err, r_rdata);
            end
            checks++;
            if (r_rd != 0 || r_wr != 0) begin errors++; $display("FAIL err_noaccess_%0d got rd=%0d wr=%0d exp 0 0", t, r_rd, r_wr); end
        end
        checks++;
        if (tb_mem[4] !== 32'h11AA_3344) begin errors++; $display("FAIL err_mem got=%h exp=11aa3344", tb_mem[4]); end
    endtask

    task automatic test_reset_mid_write();
        int seen_write;
        int resp_seen;
        tb_mem[4] = 32'h1122_3344;
        seen_write = 0;
        resp_seen  = 0;
        @(negedge clk);
        req_write  = 1'b1;
        req_size   = 2'b01;
        req_signed = 1'b0;
        req_addr   = 32'h10;
        req_wdata  = 32'h0000_BEEF;
        req_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (mem_write_en) begin seen_write = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (seen_write != 1) begin errors++; $display("FAIL rst_reach_write got=%0d exp=1", seen_write); end
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (tb_mem[4] !== 32'h1122_3344) begin errors++; $display("FAIL rst_mem got=%h exp=11223344", tb_mem[4]); end
        checks++;
        if ({resp_valid, resp_error, mem_read_en, mem_write_en} !== 4'b0000 ||
            {resp_rdata, mem_data_in, mem_address} !== 96'h0) begin
            errors++; $display("FAIL rst_outputs got flags=%b data=%h exp all zero",
                               {resp_valid, resp_error, mem_read_en, mem_write_en}, {resp_rdata, mem_data_in, mem_address});
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (resp_valid) resp_seen++;
        end
        checks++;
        if (req_ready !== 1'b1 || resp_seen != 0) begin
            errors++; $display("FAIL rst_recover got ready=%b resp=%0d exp ready=1 resp=0", req_ready, resp_seen);
        end
        $display("txn sh 0xbeef @0x10 interrupted by reset -> mem[4]=0x%08h", tb_mem[4]);
    endtask

    task automatic test_back_to_back();
        int          accepts;
        int          resps;
        int          acc_cycle [2];
        logic        will_acc;
        logic [31:0] last_rdata;
        accepts    = 0;
        resps      = 0;
        acc_cycle  = '{-1, -1};
        last_rdata = '0;
        @(negedge clk);
        req_write  = 1'b1;
        req_size   = 2'b10;
        req_signed = 1'b0;
        req_addr   = 32'h20;
        req_wdata  = 32'hCAFE_F00D;
        req_valid  = 1'b1;
        for (int c = 0; c < 14; c++) begin
            will_acc = req_valid && req_ready;
            @(posedge clk);
            @(negedge clk);
            if (resp_valid) begin
                resps++;
                last_rdata = resp_rdata;
            end
            if (will_acc) begin
                if (accepts < 2) acc_cycle[accepts] = c;
                accepts++;
                if (accepts == 1) begin
                    req_write = 1'b0;
                    req_wdata = 32'h0;
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        checks++;
        if (accepts != 2 || resps != 2) begin errors++; $display("FAIL b2b_counts got acc=%0d resp=%0d exp 2 2", accepts, resps); end
        checks++;
        if (acc_cycle[1] - acc_cycle[0] != 3) begin
            errors++; $display("FAIL b2b_spacing got=%0d exp=3", acc_cycle[1] - acc_cycle[0]);
        end
        checks++;
        if (last_rdata !== 32'hCAFE_F00D || tb_mem[8] !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL b2b_data got rdata=%h mem=%h exp cafef00d", last_rdata, tb_mem[8]);
        end
        $display("txn back-to-back sw/lw @0x20 -> accepts=%0d resps=%0d rdata=0x%08h", accepts, resps, last_rdata);
    endtask

    initial begin
        test_reset();
        test_word_store_load();
        test_subword_store();
        test_subword_load();
        test_errors();
        test_reset_mid_write();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
